// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - operand-gathering ALU with a two-stage multiply path
module alu_pipe #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CE,
    input  logic                   MODE,
    input  logic [CMD_WIDTH-1:0]   CMD,
    input  logic [1:0]             INP_VALID,
    input  logic [WIDTH-1:0]       OPA,
    input  logic [WIDTH-1:0]       OPB,
    input  logic                   CIN,
    output logic [2*WIDTH-1:0]     RES,
    output logic                   RES_VALID,
    output logic                   COUT,
    output logic                   OFLOW,
    output logic                   E,
    output logic                   G,
    output logic                   L,
    output logic                   ERR
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [WIDTH:0]       ONE_S = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [2*WIDTH+1:0]   ONE_P = {{(2*WIDTH+1){1'b0}}, 1'b1};

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 mode_q, cin_q, have_a, have_b;

    logic                 idle;
    logic [WIDTH-1:0]     a_eff, b_eff;
    logic [CMD_WIDTH-1:0] cmd_eff;
    logic                 mode_eff, cin_eff, have_a_eff, have_b_eff;
    logic                 need_a, need_b, mapped, is_mul, complete, timeout, fire;
    logic [CW-1:0]        cnt_inc;

    // Outside IDLE the captured command rules; a missing operand is taken from the bus.
    always_comb begin
        idle       = (state == S_IDLE);
        a_eff      = (idle || !have_a) ? OPA : a_q;
        b_eff      = (idle || !have_b) ? OPB : b_q;
        have_a_eff = idle ? INP_VALID[0] : (have_a | INP_VALID[0]);
        have_b_eff = idle ? INP_VALID[1] : (have_b | INP_VALID[1]);
        cmd_eff    = idle ? CMD  : cmd_q;
        mode_eff   = idle ? MODE : mode_q;
        cin_eff    = idle ? CIN  : cin_q;
    end

    always_comb begin
        mapped = 1'b1;
        need_a = 1'b1;
        need_b = 1'b1;
        if (mode_eff) begin
            case (cmd_eff)
                4, 5:                     need_b = 1'b0;
                6, 7:                     need_a = 1'b0;
                0, 1, 2, 3, 8, 9, 10:     ;
                default:                  mapped = 1'b0;
            endcase
        end else begin
            case (cmd_eff)
                6, 8, 9:                  need_b = 1'b0;
                7, 10, 11:                need_a = 1'b0;
                0, 1, 2, 3, 4, 5, 12, 13: ;
                default:                  mapped = 1'b0;
            endcase
        end
        if (!mapped) begin
            need_a = 1'b0;
            need_b = 1'b0;
        end
        is_mul   = mode_eff && mapped && (cmd_eff == 9 || cmd_eff == 10);
        complete = (!need_a || have_a_eff) && (!need_b || have_b_eff);
        cnt_inc  = cnt + 1'b1;
        timeout  = (state == S_WAIT) && !complete && (cnt_inc == TMO);
        fire     = CE && ((idle && (|INP_VALID) && complete && !is_mul) ||
                          ((state == S_WAIT) && ((complete && !is_mul) || timeout)) ||
                          (state == S_MUL));
    end

    logic [2*WIDTH-1:0] r_res;
    logic               r_cout, r_oflow, r_e, r_g, r_l, r_err;
    logic [WIDTH:0]     sum, ae, be, ce1;
    logic [WIDTH-1:0]   rw;
    logic [2*WIDTH-1:0] rot;
    logic [2*WIDTH+1:0] ax, bx, prod;

    always_comb begin
        r_res = '0; r_cout = 1'b0; r_oflow = 1'b0;
        r_e = 1'b0; r_g = 1'b0; r_l = 1'b0; r_err = 1'b0;
        sum = '0; rw = '0; rot = '0; prod = '0;
        ae  = {1'b0, a_eff};
        be  = {1'b0, b_eff};
        ce1 = {{WIDTH{1'b0}}, cin_eff};
        ax  = {{(WIDTH+2){1'b0}}, a_q};
        bx  = {{(WIDTH+2){1'b0}}, b_q};
        if (state == S_MUL) begin
            prod  = (cmd_q == 9) ? (ax + ONE_P) * (bx + ONE_P) : (ax << 1) * bx;
            r_res = prod[2*WIDTH-1:0];
        end else if (timeout) begin
            r_err = 1'b1;
        end else begin
            if (mode_eff) begin
                case (cmd_eff)
                    0: sum = ae + be;
                    1: sum = ae - be;
                    2: sum = ae + be + ce1;
                    3: sum = ae - be - ce1;
                    4: sum = ae + ONE_S;
                    5: sum = ae - ONE_S;
                    6: sum = be + ONE_S;
                    7: sum = be - ONE_S;
                    8: begin
                        r_e = (a_eff == b_eff);
                        r_g = (a_eff >  b_eff);
                        r_l = (a_eff <  b_eff);
                    end
                    default: r_err = 1'b1;
                endcase
                if (cmd_eff <= 7) begin
                    rw     = sum[WIDTH-1:0];
                    r_cout = sum[WIDTH];
                end
                // Subtraction is addition of ~B, so the sign test flips B for SUB forms.
                if (cmd_eff == 0 || cmd_eff == 2)
                    r_oflow = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (rw[WIDTH-1] != a_eff[WIDTH-1]);
                else if (cmd_eff == 1 || cmd_eff == 3)
                    r_oflow = (a_eff[WIDTH-1] != b_eff[WIDTH-1]) && (rw[WIDTH-1] != a_eff[WIDTH-1]);
            end else begin
                case (cmd_eff)
                    0:  rw = a_eff & b_eff;
                    1:  rw = ~(a_eff & b_eff);
                    2:  rw = a_eff | b_eff;
                    3:  rw = ~(a_eff | b_eff);
                    4:  rw = a_eff ^ b_eff;
                    5:  rw = ~(a_eff ^ b_eff);
                    6:  rw = ~a_eff;
                    7:  rw = ~b_eff;
                    8:  begin rw = a_eff >> 1; r_cout = a_eff[0];       end
                    9:  begin rw = a_eff << 1; r_cout = a_eff[WIDTH-1]; end
                    10: begin rw = b_eff >> 1; r_cout = b_eff[0];       end
                    11: begin rw = b_eff << 1; r_cout = b_eff[WIDTH-1]; end
                    12: begin
                        rot = {a_eff, a_eff} << b_eff[LW-1:0];
                        rw  = rot[2*WIDTH-1:WIDTH];
                        r_err = |(b_eff >> LW);
                    end
                    13: begin
                        rot = {a_eff, a_eff} >> b_eff[LW-1:0];
                        rw  = rot[WIDTH-1:0];
                        r_err = |(b_eff >> LW);
                    end
                    default: r_err = 1'b1;
                endcase
            end
            if (r_err) rw = '0;
            r_res = {{WIDTH{1'b0}}, rw};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE; cnt <= '0;
            a_q <= '0; b_q <= '0; cmd_q <= '0;
            mode_q <= 1'b0; cin_q <= 1'b0; have_a <= 1'b0; have_b <= 1'b0;
            RES <= '0; RES_VALID <= 1'b0; COUT <= 1'b0; OFLOW <= 1'b0;
            E <= 1'b0; G <= 1'b0; L <= 1'b0; ERR <= 1'b0;
        end else begin
            RES_VALID <= 1'b0;
            if (CE) begin
                if (fire) begin
                    RES <= r_res; RES_VALID <= 1'b1; COUT <= r_cout; OFLOW <= r_oflow;
                    E <= r_e; G <= r_g; L <= r_l; ERR <= r_err;
                end
                case (state)
                    S_IDLE: if (|INP_VALID) begin
                        cmd_q  <= CMD; mode_q <= MODE; cin_q <= CIN;
                        have_a <= INP_VALID[0]; have_b <= INP_VALID[1];
                        if (INP_VALID[0]) a_q <= OPA;
                        if (INP_VALID[1]) b_q <= OPB;
                        cnt <= '0;
                        if (!complete)   state <= S_WAIT;
                        else if (is_mul) state <= S_MUL;
                    end
                    S_WAIT: begin
                        cnt <= cnt_inc;
                        have_a <= have_a_eff; have_b <= have_b_eff;
                        a_q <= a_eff; b_q <= b_eff;
                        if (complete)     state <= is_mul ? S_MUL : S_IDLE;
                        else if (timeout) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed-vector bench for alu_pipe
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CE = 1'b1;
    logic        MODE = 1'b0;
    logic [3:0]  CMD = '0;
    logic [1:0]  INP_VALID = '0;
    logic [7:0]  OPA = '0, OPB = '0;
    logic        CIN = 1'b0;
    logic [15:0] RES;
    logic        RES_VALID, COUT, OFLOW, E, G, L, ERR;
    int          errors = 0;
    int          checks = 0;

    alu_pipe #(.WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
        .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .RES_VALID(RES_VALID),
        .COUT(COUT), .OFLOW(OFLOW), .E(E), .G(G), .L(L), .ERR(ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] v, input logic ci);
        MODE = m; CMD = c; OPA = a; OPB = b; INP_VALID = v; CIN = ci;
        tick();
        INP_VALID = 2'b00;
    endtask

    task automatic expect_res(input string tag, input logic [15:0] res, input logic cout,
                              input logic oflow, input logic e, input logic g, input logic l,
                              input logic err);
        check({tag, ".valid"}, 32'(RES_VALID), 32'(1'b1));
        check({tag, ".res"},   32'(RES),   32'(res));
        check({tag, ".cout"},  32'(COUT),  32'(cout));
        check({tag, ".oflow"}, 32'(OFLOW), 32'(oflow));
        check({tag, ".e"},     32'(E),     32'(e));
        check({tag, ".g"},     32'(G),     32'(g));
        check({tag, ".l"},     32'(L),     32'(l));
        check({tag, ".err"},   32'(ERR),   32'(err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int early;
        repeat (3) tick();
        rst = 1'b0;
        check("rst.res", 32'(RES), 32'h0);
        check("rst.valid", 32'(RES_VALID), 32'h0);
        check("rst.flags", 32'({COUT, OFLOW, E, G, L, ERR}), 32'h0);

        op(1, 0, 8'hFF, 8'h01, 2'b11, 0); expect_res("add_ff_01", 16'h0000, 1, 0, 0, 0, 0, 0);
        tick(); check("add.pulse_end", 32'(RES_VALID), 32'h0);
        op(1, 0, 8'h7F, 8'h01, 2'b11, 0); expect_res("add_oflow", 16'h0080, 0, 1, 0, 0, 0, 0);
        op(1, 1, 8'h05, 8'h07, 2'b11, 0); expect_res("sub_borrow", 16'h00FE, 1, 0, 0, 0, 0, 0);
        op(1, 1, 8'h80, 8'h01, 2'b11, 0); expect_res("sub_oflow", 16'h007F, 0, 1, 0, 0, 0, 0);
        op(1, 2, 8'h10, 8'h20, 2'b11, 1); expect_res("add_cin", 16'h0031, 0, 0, 0, 0, 0, 0);
        op(1, 3, 8'h10, 8'h10, 2'b11, 1); expect_res("sub_cin", 16'h00FF, 1, 0, 0, 0, 0, 0);
        op(1, 4, 8'hFF, 8'h00, 2'b01, 0); expect_res("inc_a_wrap", 16'h0000, 1, 0, 0, 0, 0, 0);
        op(1, 7, 8'h00, 8'h00, 2'b10, 0); expect_res("dec_b_wrap", 16'h00FF, 1, 0, 0, 0, 0, 0);
        op(1, 8, 8'h05, 8'h09, 2'b11, 0); expect_res("cmp_less", 16'h0000, 0, 0, 0, 0, 1, 0);
        op(1, 8, 8'h09, 8'h09, 2'b11, 0); expect_res("cmp_eq", 16'h0000, 0, 0, 1, 0, 0, 0);
        op(1, 8, 8'hA0, 8'h10, 2'b11, 0); expect_res("cmp_gt", 16'h0000, 0, 0, 0, 1, 0, 0);
        op(1, 15, 8'h12, 8'h34, 2'b11, 0); expect_res("arith_unmapped", 16'h0000, 0, 0, 0, 0, 0, 1);

        op(1, 9, 8'h03, 8'h04, 2'b11, 0);
        check("mul_inc.lat1", 32'(RES_VALID), 32'h0);
        tick(); expect_res("mul_inc", 16'h0014, 0, 0, 0, 0, 0, 0);
        op(1, 10, 8'h03, 8'h05, 2'b11, 0);
        check("mul_shl.lat1", 32'(RES_VALID), 32'h0);
        tick(); expect_res("mul_shl", 16'h001E, 0, 0, 0, 0, 0, 0);
        op(1, 9, 8'hFF, 8'hFE, 2'b11, 0); tick(); expect_res("mul_inc_max", 16'hFF00, 0, 0, 0, 0, 0, 0);

        op(0, 0, 8'hF0, 8'h3C, 2'b11, 0); expect_res("and", 16'h0030, 0, 0, 0, 0, 0, 0);
        op(0, 1, 8'hF0, 8'h3C, 2'b11, 0); expect_res("nand", 16'h00CF, 0, 0, 0, 0, 0, 0);
        op(0, 3, 8'hF0, 8'h3C, 2'b11, 0); expect_res("nor", 16'h0003, 0, 0, 0, 0, 0, 0);
        op(0, 6, 8'h0F, 8'h00, 2'b01, 0); expect_res("not_a", 16'h00F0, 0, 0, 0, 0, 0, 0);
        op(0, 8, 8'h81, 8'h00, 2'b01, 0); expect_res("shr1_a", 16'h0040, 1, 0, 0, 0, 0, 0);
        op(0, 11, 8'h00, 8'h81, 2'b10, 0); expect_res("shl1_b", 16'h0002, 1, 0, 0, 0, 0, 0);
        op(0, 12, 8'h81, 8'h01, 2'b11, 0); expect_res("rol1", 16'h0003, 0, 0, 0, 0, 0, 0);
        op(0, 12, 8'h81, 8'h07, 2'b11, 0); expect_res("rol7", 16'h00C0, 0, 0, 0, 0, 0, 0);
        op(0, 13, 8'h81, 8'h01, 2'b11, 0); expect_res("ror1", 16'h00C0, 0, 0, 0, 0, 0, 0);
        op(0, 12, 8'h81, 8'h10, 2'b11, 0); expect_res("rol_bad_b", 16'h0000, 0, 0, 0, 0, 0, 1);
        op(0, 14, 8'h81, 8'h01, 2'b11, 0); expect_res("logic_unmapped", 16'h0000, 0, 0, 0, 0, 0, 1);

        // XOR gathered over two captures; CMD changes while waiting must be ignored
        op(0, 4, 8'h0F, 8'h00, 2'b01, 0);
        early = 0;
        repeat (5) begin tick(); if (RES_VALID) early++; end
        check("xor_wait.early", 32'(early), 32'h0);
        op(0, 0, 8'h00, 8'hF0, 2'b10, 0); expect_res("xor_wait", 16'h00FF, 0, 0, 0, 0, 0, 0);

        op(1, 0, 8'h11, 8'h00, 2'b01, 0);
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(); if (RES_VALID) early++;
            if (i == 8) begin
                CE = 1'b0;
                repeat (3) begin tick(); if (RES_VALID) early++; end
                CE = 1'b1;
            end
        end
        check("timeout.early", 32'(early), 32'h0);
        tick(); expect_res("timeout", 16'h0000, 0, 0, 0, 0, 0, 1);

        op(1, 9, 8'h03, 8'h04, 2'b11, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mul_rst.valid", 32'(RES_VALID), 32'h0);
        check("mul_rst.outs", 32'({RES, COUT, OFLOW, E, G, L, ERR}), 32'h0);
        tick(); check("mul_rst.no_late", 32'(RES_VALID), 32'h0);
        op(1, 0, 8'h01, 8'h02, 2'b11, 0); expect_res("post_rst_add", 16'h0003, 0, 0, 0, 0, 0, 0);

        tick(); tick();
        check("hold.res", 32'(RES), 32'h3);
        check("hold.valid", 32'(RES_VALID), 32'h0);

        CE = 1'b0;
        op(1, 0, 8'h20, 8'h20, 2'b11, 0);
        check("ce0.valid", 32'(RES_VALID), 32'h0);
        CE = 1'b1;
        tick();
        check("ce0.no_capture", 32'(RES_VALID), 32'h0);
        check("ce0.res_held", 32'(RES), 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal 4..32, power of two).
REQ-002 Parameter CMD_WIDTH, default 4, command field width.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles spent waiting for a missing operand.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 CE  input  1  clock enable; 0 freezes all state and outputs.
REQ-007 MODE  input  1  1 = arithmetic, 0 = logical.
REQ-008 CMD  input  CMD_WIDTH  operation select.
REQ-009 INP_VALID  input  2  bit0 = OPA valid, bit1 = OPB valid.
REQ-010 OPA, OPB  input  WIDTH each  operands.
REQ-011 CIN  input  1  carry-in for the ADD_CIN and SUB_CIN commands.
REQ-012 RES  output  2*WIDTH  result, zero-extended for non-multiply commands.
REQ-013 RES_VALID  output  1  one-cycle pulse marking new RES and flag values.
REQ-014 COUT, OFLOW, E, G, L, ERR  output  1 each  carry/borrow, signed overflow, compare equal/greater/less, error.

Function
REQ-015 Arithmetic CMD map (MODE=1): 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP, 9 MUL_INC = (A+1)*(B+1), 10 MUL_SHL = (A<<1)*B.
REQ-016 Logical CMD map (MODE=0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B.
REQ-017 Unmapped CMD values: RES=0, ERR=1, RES_VALID pulse one cycle after capture.
REQ-018 Single-operand commands (INC/DEC/NOT/shift) need only their own operand's valid bit; all other commands need both operands.
REQ-019 FSM states: IDLE, WAIT, MUL. In IDLE with CE=1 and INP_VALID≠00, the block captures CMD, MODE, CIN and each valid operand.
REQ-020 IDLE transitions when all required operands are present: non-multiply commands produce RES_VALID on the next edge and stay in IDLE; multiply commands move to MUL.
REQ-021 IDLE transition when only some required operands are present: move to WAIT with the wait counter cleared.
REQ-022 WAIT: each CE=1 cycle increments the counter and captures a newly valid missing operand; CMD, MODE and CIN are ignored during WAIT.
REQ-023 WAIT completion, non-multiply: result issues on the next edge, then return to IDLE.
REQ-024 WAIT completion, multiply: move to MUL.
REQ-025 WAIT timeout: if the operand is still missing after TIMEOUT cycles, set ERR=1 and RES=0, pulse RES_VALID, return to IDLE.
REQ-026 Latency: non-multiply results appear 1 cycle after the final operand is captured; multiply results appear 2 cycles after.
REQ-027 MUL: second pipeline stage; RES_VALID issues on exit; new inputs are ignored while in MUL.
REQ-028 ADD/ADD_CIN: COUT = carry out of bit WIDTH-1. SUB/SUB_CIN: COUT = borrow (A < B + CIN, unsigned).
REQ-029 OFLOW = two's-complement signed overflow, for ADD, SUB, ADD_CIN and SUB_CIN only.
REQ-030 CMP, unsigned: exactly one of E/G/L is 1; RES=0. All other commands drive E=G=L=0.
REQ-031 ROL/ROR: rotate A by B[log2(WIDTH)-1:0]. Any higher bit of B set gives ERR=1, RES=0.
REQ-032 INC/DEC and shifts wrap modulo 2^WIDTH; the carry or lost bit goes to COUT.
REQ-033 RES and all flags hold their last values between RES_VALID pulses. Flags not defined for a command are driven 0 at its RES_VALID.
REQ-034 CE=0 in any state: no state, counter or output change, and no RES_VALID. The wait timeout counts only CE=1 cycles.

Reset
REQ-035 rst=1 at a clock edge returns the FSM to IDLE and clears the counter, captured operands, RES, RES_VALID, COUT, OFLOW, E, G, L and ERR to 0.
REQ-036 rst takes priority over CE. Reset during WAIT or MUL discards the operation and produces no RES_VALID.

Verification
REQ-037 WIDTH=8, MODE=1, CMD=0, OPA=0xFF, OPB=0x01, INP_VALID=11 -> next cycle RES=0x000, COUT=1, OFLOW=0, RES_VALID=1.
REQ-038 MODE=1, CMD=9, OPA=3, OPB=4, INP_VALID=11 -> RES=20 with RES_VALID exactly 2 cycles after capture.
REQ-039 MODE=0, CMD=4, INP_VALID=01 with OPA=0x0F, then 5 idle cycles, then INP_VALID=10 with OPB=0xF0 -> RES=0xFF one cycle after OPB is captured, ERR=0.
REQ-040 MODE=1, CMD=0, INP_VALID=01, OPB never valid -> ERR=1, RES=0, RES_VALID after 16 CE=1 cycles; CE=0 cycles inserted mid-wait extend the wait one-for-one.
REQ-041 MODE=0, CMD=12, OPA=0x81, OPB=0x01 -> RES=0x03; repeated with OPB=0x10 -> ERR=1, RES=0.
REQ-042 Multiply in MUL state with rst asserted -> no RES_VALID, all outputs 0, next operation accepted normally.
